mem_burst_master: RTL and testbench

- Upstream driver for the single-port handshake memory (`clk_i`, `addr_i`, `wdata_i`, `rdata_o`, `wr_rd_i`, `valid_i`, `ready_o`).
- Accepts one burst command (start address, length, direction) and issues one memory access per word.
- Write words come in from a valid/ready stream; read words go out through a small FIFO that absorbs back-pressure.
- This is the front-door access path used alongside back-door load/dump in the memory benches.

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_burst_fifo.sv | 50 +++++
 rtl/mem_burst_master.sv | 130 +++++++++++++
 tb/tb_mem_burst_master.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Types and defaults shared by the burst master and its read-return FIFO.
package mem_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_ADDR_WIDTH = 22;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_burst_fifo.sv
// Synchronous FIFO for returning read data; head word comes straight from storage registers.
module mem_burst_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [PW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = (count_o == DEPTH_C);
  assign empty_o    = (count_o == '0);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[PW-1:0]];

  // NOTE: storage has no reset; emptiness is defined by the pointers alone,
  // and leaving the array unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (PW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (PW + 1)'(1);
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// Burst front-end for the single-port handshake memory: one command, one memory
// beat per word, write words from a stream, read words returned through a FIFO.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [WIDTH-1:0]      wd_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_rd_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  last_word;
  logic                  read_space;
  logic                  beat;
  logic                  fifo_push;
  logic [PW:0]           fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign last_word  = (rem_q == (ADDR_WIDTH + 1)'(1));
  // Reads complete in the handshake cycle, so FIFO occupancy alone bounds issue.
  assign read_space = (fifo_count < DEPTH_C);

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    cmd_ready_o = 1'b0;
    mem_valid_o = 1'b0;
    mem_wr_rd_o = RD;
    mem_wdata_o = '0;
    wd_ready_o  = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_len_i == '0)     state_d = S_DONE;
          else if (cmd_wr_i == WR) state_d = S_WRITE;
          else                     state_d = S_READ;
        end
      end
      S_WRITE: begin
        mem_valid_o = wd_valid_i;
        mem_wr_rd_o = WR;
        mem_wdata_o = wd_data_i;
        wd_ready_o  = wd_valid_i & mem_ready_i;
        if (wd_valid_i && mem_ready_i && last_word) state_d = S_DONE;
      end
      S_READ: begin
        mem_valid_o = read_space;
        if (read_space && mem_ready_i && last_word) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign beat = mem_valid_o & mem_ready_i;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cmd_ready_o && cmd_valid_i) begin
        addr_q <= cmd_addr_i;
        rem_q  <= cmd_len_i;
      end else if (beat) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        rem_q  <= rem_q - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != S_IDLE);
  assign fifo_push  = beat && (state_q == S_READ) && !fifo_full;
  assign rd_valid_o = ~fifo_empty;

  mem_burst_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (mem_rdata_i),
    .pop_i       (rd_ready_i),
    .pop_data_o  (rd_data_o),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural memory, write/read scoreboards, one task per scenario.
module tb_mem_burst_master;

  logic        clk;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wr_i;
  logic [21:0] cmd_addr_i;
  logic [22:0] cmd_len_i;
  logic        wd_valid_i;
  logic        wd_ready_o;
  logic [15:0] wd_data_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [15:0] rd_data_o;
  logic [21:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_wr_rd_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [15:0] mem_rdata_i;
  logic        busy_o;
  logic        done_o;

  mem_burst_master dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_wr_i    (cmd_wr_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wd_valid_i  (wd_valid_i),
    .wd_ready_o  (wd_ready_o),
    .wd_data_i   (wd_data_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wr_rd_o (mem_wr_rd_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct packed {
    logic [21:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int accept_cyc = 0;
  int last_beat_cyc = 0;
  int first_beat_cyc = -1;
  int ready_mode = 0;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] ref_mem   [logic [21:0]];
  logic [15:0] mem_model [logic [21:0]];

  bit          hold_v = 0;
  logic [21:0] hold_addr;
  logic [15:0] hold_data;
  logic        hold_wr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory ready pattern: always ready, or ready one cycle in three.
  initial begin
    mem_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_ready_i = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  function automatic logic [15:0] init_word(input logic [21:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_word(input logic [21:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Memory model plus scoreboard, evaluated on the falling edge for the coming rising edge.
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold_v = 0;
    end else begin
      if (hold_v && mem_valid_o) begin
        checks++;
        if ({mem_addr_o, mem_wdata_o, mem_wr_rd_o} !== {hold_addr, hold_data, hold_wr}) begin
          errors++;
          $display("FAIL stall_stable: got addr=%h data=%h wr=%b, held addr=%h data=%h wr=%b",
                   mem_addr_o, mem_wdata_o, mem_wr_rd_o, hold_addr, hold_data, hold_wr);
        end
      end
      hold_v    = mem_valid_o && !mem_ready_i;
      hold_addr = mem_addr_o;
      hold_data = mem_wdata_o;
      hold_wr   = mem_wr_rd_o;

      if (mem_valid_o && mem_ready_i) begin
        beats++;
        last_beat_cyc = cyc;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        if (mem_wr_rd_o) begin
          mem_model[mem_addr_o] = mem_wdata_o;
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: addr=%h data=%h, no write expected", mem_addr_o, mem_wdata_o);
          end else begin
            wr_exp_t e;
            e = wr_q.pop_front();
            if ({mem_addr_o, mem_wdata_o} !== {e.addr, e.data}) begin
              errors++;
              $display("FAIL wr_beat: got addr=%h data=%h, expected addr=%h data=%h",
                       mem_addr_o, mem_wdata_o, e.addr, e.data);
            end
          end
        end
      end

      if (rd_valid_o && rd_ready_i) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got %h, no read word expected", rd_data_o);
        end else begin
          logic [15:0] exp_rd;
          exp_rd = rd_q.pop_front();
          if (rd_data_o !== exp_rd) begin
            errors++;
            $display("FAIL rd_word: got %h, expected %h", rd_data_o, exp_rd);
          end
        end
      end

      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : init_word(mem_addr_o);
  end

  task automatic push_write(input logic [21:0] addr, input logic [15:0] data);
    wr_exp_t e;
    e.addr = addr;
    e.data = data;
    wr_q.push_back(e);
    ref_mem[addr] = data;
  endtask

  task automatic issue_cmd(input logic wr, input logic [21:0] addr, input logic [22:0] len,
                           input bit hold_valid);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got = 1;
        break;
      end
    end
    accept_cyc = cyc;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready_o=%b after 50 cycles, expected 1", cmd_ready_o);
    end
    @(posedge clk);
    #1;
    if (hold_valid) begin
      cmd_wr_i   = ~wr;
      cmd_addr_i = 22'($urandom);
      cmd_len_i  = 23'($urandom);
    end else begin
      cmd_valid_i = 1'b0;
    end
  endtask

  task automatic send_words(input logic [15:0] base, input int n, input bit gaps);
    bit got;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        wd_valid_i = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      wd_valid_i = 1'b1;
      wd_data_i  = base + 16'(i);
      got = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (wd_ready_o) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL wd_consume: word %0d wd_ready_o=%b after 200 cycles, expected 1", i, wd_ready_o);
        wd_valid_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    wd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (done_cnt != prev) return;
      @(negedge clk);
    end
    checks++;
    if (done_cnt == prev) begin
      errors++;
      $display("FAIL done_timeout: done count=%0d after %0d cycles, expected %0d", done_cnt, budget, prev + 1);
    end
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_wr_i    = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    wd_valid_i  = 1'b0;
    wd_data_i   = '0;
    rd_ready_i  = 1'b0;
    mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_valid_o, mem_wr_rd_o, rd_valid_o, wd_ready_o, done_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid/wr/rdv/wdr/done/busy=%b, expected 000000",
               {mem_valid_o, mem_wr_rd_o, rd_valid_o, wd_ready_o, done_o, busy_o});
    end
    checks++;
    if ({mem_addr_o, mem_wdata_o} !== 38'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h, expected 0", mem_addr_o, mem_wdata_o);
    end
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cmd_ready=%b busy=%b, expected 1 0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_write_burst();
    int d0;
    ready_mode     = 0;
    d0             = done_cnt;
    first_beat_cyc = -1;
    for (int i = 0; i < 4; i++) push_write(22'h10 + 22'(i), 16'hA000 + 16'(i));
    fork
      issue_cmd(1'b1, 22'h10, 23'd4, 0);
      send_words(16'hA000, 4, 0);
    join
    wait_done(d0, 50);
    repeat (3) @(negedge clk);
    checks++;
    if (first_beat_cyc !== accept_cyc + 1) begin
      errors++;
      $display("FAIL wr_first_latency: first beat cycle %0d, expected %0d", first_beat_cyc, accept_cyc + 1);
    end
    checks++;
    if (done_cyc !== last_beat_cyc + 1) begin
      errors++;
      $display("FAIL wr_done_latency: done cycle %0d, expected %0d", done_cyc, last_beat_cyc + 1);
    end
    checks++;
    if (done_cnt !== d0 + 1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL wr_complete: done count %0d, left %0d writes, expected %0d and 0",
               done_cnt, wr_q.size(), d0 + 1);
    end
  endtask

  task automatic test_read_backpressure();
    int d0;
    int b0;
    bit drained;
    ready_mode = 0;
    rd_ready_i = 1'b0;
    d0         = done_cnt;
    b0         = beats;
    for (int i = 0; i < 6; i++) rd_q.push_back(ref_word(22'h10 + 22'(i)));
    issue_cmd(1'b0, 22'h10, 23'd6, 0);
    repeat (10) @(negedge clk);
    checks++;
    if (beats - b0 !== 4) begin
      errors++;
      $display("FAIL rd_issue_count: got %0d reads while stalled, expected 4", beats - b0);
    end
    checks++;
    if (mem_valid_o !== 1'b0 || rd_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_full_stall: got mem_valid=%b rd_valid=%b, expected 0 1", mem_valid_o, rd_valid_o);
    end
    @(posedge clk);
    #1;
    rd_ready_i = 1'b1;
    drained = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_q.size() == 0 && done_cnt != d0) begin
        drained = 1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!drained || rd_valid_o !== 1'b0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL rd_drain: left %0d words, rd_valid=%b, done count %0d, expected 0 0 %0d",
               rd_q.size(), rd_valid_o, done_cnt, d0 + 1);
    end
  endtask

  task automatic test_wrap();
    int d0;
    ready_mode = 0;
    d0         = done_cnt;
    push_write(22'h3FFFFE, 16'hB000);
    push_write(22'h3FFFFF, 16'hB001);
    push_write(22'h000000, 16'hB002);
    fork
      issue_cmd(1'b1, 22'h3FFFFE, 23'd3, 0);
      send_words(16'hB000, 3, 0);
    join
    wait_done(d0, 50);
    @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL wrap_complete: left %0d writes, done count %0d, expected 0 and %0d",
               wr_q.size(), done_cnt, d0 + 1);
    end
  endtask

  task automatic test_len_zero();
    int d0;
    int b0;
    d0 = done_cnt;
    b0 = beats;
    issue_cmd(1'b1, 22'h55, 23'd0, 0);
    wait_done(d0, 20);
    repeat (4) @(negedge clk);
    checks++;
    if (beats !== b0) begin
      errors++;
      $display("FAIL len0_beats: got %0d memory beats, expected 0", beats - b0);
    end
    checks++;
    if (done_cnt !== d0 + 1 || done_cyc - accept_cyc < 1 || done_cyc - accept_cyc > 2) begin
      errors++;
      $display("FAIL len0_done: done count %0d at offset %0d, expected %0d at offset 1..2",
               done_cnt, done_cyc - accept_cyc, d0 + 1);
    end
  endtask

  task automatic test_stalls();
    int d0;
    ready_mode = 1;
    d0         = done_cnt;
    for (int i = 0; i < 8; i++) push_write(22'h200 + 22'(i), 16'hC000 + 16'(i));
    fork
      issue_cmd(1'b1, 22'h200, 23'd8, 1);
      send_words(16'hC000, 8, 1);
    join
    wait_done(d0, 200);
    cmd_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    ready_mode = 0;
    checks++;
    if (wr_q.size() != 0 || done_cnt !== d0 + 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_complete: left %0d writes, done count %0d, busy=%b, expected 0 %0d 0",
               wr_q.size(), done_cnt, busy_o, d0 + 1);
    end
  endtask

  task automatic test_mid_reset();
    int d0;
    int b0;
    ready_mode = 0;
    rd_ready_i = 1'b0;
    d0         = done_cnt;
    b0         = beats;
    for (int i = 0; i < 8; i++) rd_q.push_back(ref_word(22'h100 + 22'(i)));
    issue_cmd(1'b0, 22'h100, 23'd8, 0);
    for (int n = 0; n < 50 && beats < b0 + 3; n++) @(negedge clk);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    rd_q.delete();
    wr_q.delete();
    checks++;
    if ({mem_valid_o, mem_wr_rd_o, rd_valid_o, wd_ready_o, done_o, busy_o} !== 6'b0 ||
        {mem_addr_o, mem_wdata_o} !== 38'd0) begin
      errors++;
      $display("FAIL midrst_async: got valid/wr/rdv/wdr/done/busy=%b addr=%h, expected 000000 and 0",
               {mem_valid_o, mem_wr_rd_o, rd_valid_o, wd_ready_o, done_o, busy_o}, mem_addr_o);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready_o !== 1'b1 || rd_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release: got cmd_ready=%b rd_valid=%b busy=%b, expected 1 0 0",
               cmd_ready_o, rd_valid_o, busy_o);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || mem_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone: done count %0d mem_valid=%b, expected %0d 0", done_cnt, mem_valid_o, d0);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_backpressure();
    test_wrap();
    test_len_zero();
    test_stalls();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
